// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit for MULT/MULTU/DIV/DIVU with HI/LO result registers.
// One shift-add or restoring-subtract step per clock gives a fixed 33-cycle latency.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoWre,
  input  logic             HiLoSel,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT state, nextState;

  logic [1:0]         opReg;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] work;
  logic               resSign;
  logic               remSign;
  logic [5:0]         count;
  logic               doneReg;

  logic               isSigned;
  logic               lastIter;
  logic               hiLoWriteEn;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     shiftedRem;
  logic               trialOk;
  logic [WIDTH-1:0]   remDiff;
  logic [2*WIDTH-1:0] mulStep;
  logic [2*WIDTH-1:0] divStep;
  logic [2*WIDTH-1:0] workNeg;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic [2*WIDTH-1:0] fixResult;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = RUN;
      RUN:     if (lastIter) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy        = (state != IDLE);
    Done        = doneReg;
    hiLoWriteEn = (state == IDLE) && !Start && HiLoWre;
  end

  // Both algorithms start from {0, operand}: multiplier for multiply, dividend for divide.
  always_comb begin
    isSigned = Op[0];
    absA     = (isSigned && A[WIDTH-1]) ? (~A + 1'b1) : A;
    absB     = (isSigned && B[WIDTH-1]) ? (~B + 1'b1) : B;
    lastIter = (count == 6'(WIDTH - 1));
  end

  always_comb begin
    mulSum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, magB} : {(WIDTH+1){1'b0}});
    mulStep = {mulSum, work[WIDTH-1:1]};
  end

  // Shifted remainder is below 2*divisor, so a successful trial always fits back into WIDTH bits.
  always_comb begin
    shiftedRem = work[2*WIDTH-1:WIDTH-1];
    trialOk    = (shiftedRem >= {1'b0, magB});
    remDiff    = shiftedRem[WIDTH-1:0] - magB;
    divStep    = trialOk ? {remDiff, work[WIDTH-2:0], 1'b1}
                         : {work[2*WIDTH-2:0], 1'b0};
  end

  // A zero divisor keeps the all-ones quotient unsigned while the remainder sign fix restores A.
  always_comb begin
    workNeg   = ~work + 1'b1;
    quotFix   = (resSign && (magB != '0)) ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
    remFix    = remSign ? (~work[2*WIDTH-1:WIDTH] + 1'b1) : work[2*WIDTH-1:WIDTH];
    fixResult = opReg[1] ? {remFix, quotFix} : (resSign ? workNeg : work);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      opReg   <= '0;
      magB    <= '0;
      work    <= '0;
      resSign <= 1'b0;
      remSign <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            opReg   <= Op;
            magB    <= absB;
            work    <= {{WIDTH{1'b0}}, absA};
            resSign <= isSigned & (A[WIDTH-1] ^ B[WIDTH-1]);
            remSign <= isSigned & A[WIDTH-1];
            count   <= '0;
          end
        end
        RUN: begin
          work  <= opReg[1] ? divStep : mulStep;
          count <= count + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HI      <= '0;
      LO      <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (state == FIX);
      if (state == FIX) begin
        HI <= fixResult[2*WIDTH-1:WIDTH];
        LO <= fixResult[WIDTH-1:0];
      end else if (hiLoWriteEn) begin
        if (HiLoSel) begin
          HI <= WriteData;
        end else begin
          LO <= WriteData;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases with literal results plus randomized
// operations, all compared every cycle against a cycle-level arithmetic model.
module tb_mul_div_unit;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HiLoWre;
  logic        HiLoSel;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .HiLoWre   (HiLoWre),
    .HiLoSel   (HiLoSel),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .HI        (HI),
    .LO        (LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Architectural result as {HI, LO}, straight from integer arithmetic.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [63:0] res;
    case (op)
      2'b00: res = {32'b0, a} * {32'b0, b};
      2'b01: begin
        sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res = sp;
      end
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFFFFFF};
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          res = {32'h0, 32'h80000000};
        end else begin
          sq  = $signed(a) / $signed(b);
          sr  = $signed(a) % $signed(b);
          res = {sr, sq};
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h80000000;
      3:       v = 32'h1;
      4:       v = $urandom_range(0, 255);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Cycle model: a countdown to the result edge plus the architectural HI/LO state.
  int          remain;
  logic [31:0] mHI;
  logic [31:0] mLO;
  logic        mBusy;
  logic        mDone;
  logic [63:0] pend;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      remain = 0;
      mHI    = 32'h0;
      mLO    = 32'h0;
      mBusy  = 1'b0;
      mDone  = 1'b0;
      pend   = 64'h0;
    end else begin
      mDone = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          mHI   = pend[63:32];
          mLO   = pend[31:0];
          mDone = 1'b1;
        end
      end else if (Start) begin
        pend   = refResult(Op, A, B);
        remain = 33;
      end else if (HiLoWre) begin
        if (HiLoSel) mHI = WriteData;
        else         mLO = WriteData;
      end
      mBusy = (remain > 0);
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("cycBusy", Busy, mBusy);
      checkOutput("cycDone", Done, mDone);
      checkOutput("cycHI", HI, mHI);
      checkOutput("cycLO", LO, mLO);
    end
  end

  // Called at a negedge; the start is taken on the following rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Returns at the negedge where Done is seen, with n = cycles since the start edge.
  task automatic waitDone(input bit noise, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      Start   = 1'b0;
      HiLoWre = 1'b0;
      if (noise && !Done) begin
        Start     = ($urandom_range(0, 3) == 0);
        HiLoWre   = ($urandom_range(0, 3) == 0);
        HiLoSel   = $urandom_range(0, 1);
        WriteData = $urandom;
        Op        = $urandom_range(0, 3);
        A         = $urandom;
        B         = $urandom;
      end
    end while (!Done && n < 40);
    Start   = 1'b0;
    HiLoWre = 1'b0;
  endtask

  initial begin
    int n;
    int doneSeen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] r;

    RST = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HiLoWre = 1'b0; HiLoSel = 1'b0; WriteData = '0;
    #2 RST = 1'b0;
    #1;
    checkOutput("rstBusy", Busy, 0);
    checkOutput("rstDone", Done, 0);
    checkOutput("rstHI", HI, 0);
    checkOutput("rstLO", LO, 0);
    checkEn = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(0, n);
    checkOutput("multuLatency", n, 33);
    checkOutput("multuHI", HI, 32'hFFFFFFFE);
    checkOutput("multuLO", LO, 32'h00000001);
    @(negedge CLK);
    checkOutput("doneOneCycle", Done, 0);

    applyStimulus(2'b01, 32'hFFFFFFFD, 32'd7);
    waitDone(0, n);
    checkOutput("multHI", HI, 32'hFFFFFFFF);
    checkOutput("multLO", LO, 32'hFFFFFFEB);

    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2);
    waitDone(0, n);
    checkOutput("divLO", LO, 32'hFFFFFFFD);
    checkOutput("divHI", HI, 32'hFFFFFFFF);

    applyStimulus(2'b10, 32'h64, 32'h0);
    waitDone(0, n);
    checkOutput("divuZeroLatency", n, 33);
    checkOutput("divuZeroLO", LO, 32'hFFFFFFFF);
    checkOutput("divuZeroHI", HI, 32'h64);

    applyStimulus(2'b11, 32'hFFFFFFF9, 32'h0);
    waitDone(0, n);
    checkOutput("divZeroLO", LO, 32'hFFFFFFFF);
    checkOutput("divZeroHI", HI, 32'hFFFFFFF9);

    applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF);
    waitDone(0, n);
    checkOutput("divOvfLatency", n, 33);
    checkOutput("divOvfLO", LO, 32'h80000000);
    checkOutput("divOvfHI", HI, 32'h0);

    HiLoWre = 1'b1; HiLoSel = 1'b1; WriteData = 32'h12345678;
    @(negedge CLK);
    HiLoWre = 1'b0;
    checkOutput("mthiHI", HI, 32'h12345678);
    checkOutput("mthiLO", LO, 32'h80000000);

    applyStimulus(2'b00, 32'd3, 32'd5);
    repeat (4) @(negedge CLK);
    HiLoWre = 1'b1; HiLoSel = 1'b1; WriteData = 32'hCAFEF00D;
    @(negedge CLK);
    HiLoWre = 1'b0;
    checkOutput("busyWriteHI", HI, 32'h12345678);
    waitDone(0, n);
    checkOutput("busyMulHI", HI, 32'h0);
    checkOutput("busyMulLO", LO, 32'd15);

    @(negedge CLK);
    Start = 1'b1; Op = 2'b00; A = 32'd2; B = 32'd3;
    HiLoWre = 1'b1; HiLoSel = 1'b0; WriteData = 32'hDEADBEEF;
    @(negedge CLK);
    Start = 1'b0; HiLoWre = 1'b0;
    checkOutput("startWinsLO", LO, 32'd15);
    waitDone(0, n);
    checkOutput("startWinsLatency", n, 33);
    checkOutput("startWinsResult", LO, 32'd6);

    applyStimulus(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    Start = 1'b1; Op = 2'b00; A = 32'd50; B = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    waitDone(0, n);
    checkOutput("ignoreStartLO", LO, 32'd14);
    checkOutput("ignoreStartHI", HI, 32'd2);

    applyStimulus(2'b10, 32'hFFFFFFFF, 32'h10);
    checkOutput("b2bBusy", Busy, 1);
    checkOutput("b2bDone", Done, 0);
    waitDone(0, n);
    checkOutput("b2bLatency", n, 33);
    checkOutput("b2bLO", LO, 32'h0FFFFFFF);
    checkOutput("b2bHI", HI, 32'hF);

    applyStimulus(2'b01, 32'h00012345, 32'h00006789);
    repeat (13) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("abortBusy", Busy, 0);
    checkOutput("abortDone", Done, 0);
    checkOutput("abortHI", HI, 0);
    checkOutput("abortLO", LO, 0);
    @(negedge CLK);
    RST = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done) doneSeen++;
    end
    checkOutput("noDoneAfterAbort", doneSeen, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        HiLoWre   = $urandom_range(0, 1);
        HiLoSel   = $urandom_range(0, 1);
        WriteData = $urandom;
        @(negedge CLK);
      end
      HiLoWre = 1'b0;
      rop = $urandom_range(0, 3);
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus(rop, ra, rb);
      waitDone(1, n);
      checkOutput("randLatency", n, 33);
      r = refResult(rop, ra, rb);
      checkOutput("randHiLo", {HI, LO}, r);
    end

    @(negedge CLK);
    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
